// File: rtl/bcd_pkg.sv
// Shared constants for the serial packed-BCD arithmetic blocks.
package bcd_pkg;

   localparam int          BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;
   localparam logic [3:0]  BCD_ADJ = 4'd6;

   localparam logic [1:0]  IDLE = 2'd0;
   localparam logic [1:0]  RUN  = 2'd1;
   localparam logic [1:0]  DONE = 2'd2;

   function automatic logic is_bad_digit(input logic [BCD_W-1:0] d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One decimal digit of add/subtract: nine's-complements B when subtracting,
// then applies the +6 decimal correction on the full 5-bit raw sum.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] a_d,
   input  logic [BCD_W-1:0] b_d,
   input  logic             sub,
   input  logic             carry,
   output logic [BCD_W-1:0] digit,
   output logic             carry_next,
   output logic             bad_digit
);

   logic [BCD_W-1:0] b_eff;
   logic [BCD_W:0]   raw;
   logic [BCD_W:0]   adj;

   always_comb begin
      // Illegal B digits wrap modulo 16 here; the result is garbage but repeatable.
      b_eff      = sub ? (BCD_MAX - b_d) : b_d;
      raw        = {1'b0, a_d} + {1'b0, b_eff} + {{BCD_W{1'b0}}, carry};
      adj        = raw + {1'b0, BCD_ADJ};
      digit      = raw[BCD_W-1:0];
      carry_next = 1'b0;
      if (raw > {1'b0, BCD_MAX}) begin
         digit      = adj[BCD_W-1:0];
         carry_next = 1'b1;
      end
      bad_digit  = is_bad_digit(a_d) | is_bad_digit(b_d);
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first,
// with ready/valid handshakes on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   RUN   | processing digit idx, operands shift right one digit per cycle
//   DONE  | result held with out_valid high until out_ready
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BCD_W*N_DIGITS-1:0] a,
   input  logic [BCD_W*N_DIGITS-1:0] b,
   input  logic                      sub,
   input  logic                      cin,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BCD_W*N_DIGITS-1:0] sum,
   output logic                      cout,
   output logic                      invalid
);

   localparam int              W        = BCD_W * N_DIGITS;
   localparam int              IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

   logic [1:0]       state_q,   state_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [W-1:0]     opa_q,     opa_d;
   logic [W-1:0]     opb_q,     opb_d;
   logic             sub_q,     sub_d;
   logic             carry_q,   carry_d;
   logic [W-1:0]     sum_q,     sum_d;
   logic             cout_q,    cout_d;
   logic             invalid_q, invalid_d;

   logic [BCD_W-1:0] step_digit;
   logic             step_carry;
   logic             step_bad;

   bcd_digit_step u_step (
      .a_d        (opa_q[BCD_W-1:0]),
      .b_d        (opb_q[BCD_W-1:0]),
      .sub        (sub_q),
      .carry      (carry_q),
      .digit      (step_digit),
      .carry_next (step_carry),
      .bad_digit  (step_bad)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      invalid_d = invalid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = RUN;
               idx_d     = '0;
               opa_d     = a;
               opb_d     = b;
               sub_d     = sub;
               // Subtraction runs as A + 9's(B) + carry, so borrow-in becomes an inverted carry.
               carry_d   = sub ? ~cin : cin;
               invalid_d = 1'b0;
            end
         end
         RUN: begin
            sum_d[idx_q*BCD_W +: BCD_W] = step_digit;
            carry_d   = step_carry;
            invalid_d = invalid_q | step_bad;
            opa_d     = opa_q >> BCD_W;
            opb_d     = opb_q >> BCD_W;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               cout_d  = step_carry;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         sub_q     <= 1'b0;
         carry_q   <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         sub_q     <= sub_d;
         carry_q   <= carry_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         invalid_q <= invalid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign invalid   = invalid_q;

endmodule
